multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: opcode  input  6  instruction bits [31:26] from IR.
REQ-004 SHALL have port: func  input  6  instruction bits [5:0] from IR.
REQ-005 SHALL have port: mem_ready  input  1  memory completes access this cycle.
REQ-006 SHALL have outputs, each 1 bit: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, instr_done, illegal_op.
REQ-007 SHALL have 2-bit outputs:
- alu_src_b: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op: 00 MTYPE add, 01 BTYPE sub, 10 RTYPE func-decoded.
- pc_src: 00 ALU, 01 ALUOut, 10 jump target, 11 reg A.
- reg_dst: 00 rt, 01 rd, 10 r31.
- mem_to_reg: 00 ALUOut, 01 MDR, 10 PC.

Function
REQ-008 SHALL be a Moore FSM with a 4-bit state register. Codes: FETCH 0, DECODE 1, MADDR 2, MREAD 3, MWB 4, MWRITE 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JAL 12, JR 13.
REQ-009 SHALL drive every output not listed for a state to 0.
REQ-010 FETCH SHALL drive mem_read=1, alu_src_b=01. It SHALL assert ir_write=1 and pc_write=1 only in the cycle mem_ready=1. It SHALL stay in FETCH while mem_ready=0, then go to DECODE.
REQ-011 DECODE SHALL drive alu_src_b=11, alu_op=00. It SHALL then go to:
- MADDR for opcode 100011 or 101011.
- REXEC for 000000.
- BRANCH for 000100.
- JUMP for 000010.
- IEXEC for 001000.
- FETCH for any other opcode, with illegal_op=1 for that cycle.
REQ-012 MADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00. It SHALL go to MREAD for lw and to MWRITE for sw.
REQ-013 MREAD SHALL drive mem_read=1, i_or_d=1. It SHALL hold until mem_ready=1, then go to MWB.
REQ-014 MWRITE SHALL drive mem_write=1, i_or_d=1. It SHALL hold until mem_ready=1, then go to FETCH.
REQ-015 MWB SHALL drive reg_write=1, mem_to_reg=01, reg_dst=00, then go to FETCH.
REQ-016 REXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to RWB. RWB SHALL drive reg_write=1, reg_dst=01, then go to FETCH.
REQ-017 BRANCH SHALL drive alu_src_a=1, alu_op=01, pc_write_cond=1, pc_src=01, then go to FETCH.
REQ-018 JUMP SHALL drive pc_write=1, pc_src=10, then go to FETCH.
REQ-019 IEXEC SHALL drive alu_src_a=1, alu_src_b=10, then go to IWB. IWB SHALL drive reg_write=1, reg_dst=00, then go to FETCH.
REQ-020 instr_done SHALL be 1 in any cycle where the next state is FETCH and the current state is not FETCH or DECODE.
REQ-021 Latencies, counting from FETCH and assuming mem_ready always 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3.

Reset
REQ-022 While rst=0, the state SHALL be FETCH and all outputs SHALL be 0, with no dependence on clk.
REQ-023 After rst releases, the first clock edge SHALL execute FETCH normally.
REQ-024 A reset arriving mid-instruction, including during a memory wait, SHALL abandon that instruction with no further write strobes.

Configuration
REQ-025 Macro JAL_JR_EN defined SHALL enable two extra decodes in DECODE:
- opcode 000011 SHALL go to JAL. JAL SHALL drive pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10, then go to FETCH.
- opcode 000000 with func 001000 SHALL go to JR. JR SHALL drive pc_write=1, pc_src=11, then go to FETCH.
REQ-026 Without JAL_JR_EN:
- opcode 000011 SHALL be illegal.
- func 001000 SHALL follow the R-type path.
- States 12 and 13 SHALL be unreachable.

Verification
REQ-027 Bench SHALL cover lw (opcode 100011) with mem_ready=1 throughout: states 0,1,2,3,4 in order; reg_write=1 with mem_to_reg=01 in cycle 5; instr_done=1 in cycle 5.
REQ-028 Bench SHALL cover sw (opcode 101011) with mem_ready low for 3 cycles in MWRITE: mem_write held 4 cycles; instr_done=1 only in the ready cycle.
REQ-029 Bench SHALL cover R-type add (func 100000): alu_op=10 in REXEC; reg_write=1 with reg_dst=01 in RWB; return to FETCH.
REQ-030 Bench SHALL cover opcode 111111: illegal_op=1 in DECODE; next state FETCH; no reg_write or mem_write asserted.
REQ-031 Bench SHALL cover rst pulsed low mid-MREAD: all outputs 0 immediately; state FETCH after release.
REQ-032 Bench SHALL cover, with JAL_JR_EN defined, jal (000011): reg_dst=10, mem_to_reg=10, pc_src=10. It SHALL cover jr (000000 / 001000): pc_src=11.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: state-decoded datapath strobes with memory handshake.
// Define JAL_JR_EN to add the JAL (opcode 000011) and JR (R-type func 001000) paths.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg
);

`ifdef JAL_JR_EN
    localparam bit JalJrEn = 1'b1;
`else
    localparam bit JalJrEn = 1'b0;
`endif

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MADDR = 4'd2,  MREAD  = 4'd3,
        MWB    = 4'd4,  MWRITE = 4'd5,  REXEC = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  IEXEC = 4'd10, IWB    = 4'd11,
        JAL    = 4'd12, JR     = 4'd13
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_d;
    end

    // Outputs decode the current state (plus mem_ready/opcode where the handshake
    // needs it) and are forced to zero for as long as reset is held.
    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        if (rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else begin
                        state_d  = FETCH;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        6'b100011, 6'b101011: state_d = MADDR;
                        6'b000000: state_d = (JalJrEn && func == 6'b001000) ? JR : REXEC;
                        6'b000100: state_d = BRANCH;
                        6'b000010: state_d = JUMP;
                        6'b001000: state_d = IEXEC;
                        6'b000011: begin
                            state_d    = JalJrEn ? JAL : FETCH;
                            illegal_op = !JalJrEn;
                        end
                        default: illegal_op = 1'b1;
                    endcase
                end
                MADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == 6'b101011) ? MWRITE : MREAD;
                end
                MREAD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    state_d  = mem_ready ? MWB : MREAD;
                end
                MWRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    state_d   = mem_ready ? FETCH : MWRITE;
                end
                MWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                REXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = RWB;
                end
                RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = IWB;
                end
                IWB: reg_write = 1'b1;
                JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                JR: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b11;
                end
                default: state_d = FETCH;
            endcase
            instr_done = (state_d == FETCH) && (state_q != FETCH) && (state_q != DECODE);
        end
    end

endmodule
